// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: ID-stage decode controller with a registered ID/EX
// control bundle, valid/ready handshake, flush and divide busy sequencer.
// Optional feature macro: DECODE_MEXT_EN enables M-extension decode and the
// divide occupancy sequencer. Without it, M encodings decode as illegal and
// busy is tied low.
module decode_ctrl_stage #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 33,
    parameter int ALUCTL_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                reg_write,
    output logic                mem_write,
    output logic                jump,
    output logic                branch,
    output logic                alu_src,
    output logic                srca_src,
    output logic                jump_reg,
    output logic                is_word_op,
    output logic                is_muldiv,
    output logic                illegal,
    output logic [1:0]          result_src,
    output logic [2:0]          imm_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                busy
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

    // Writeback select, immediate format and ALU operation encodings.
    localparam logic [1:0] RES_MEM   = 2'b01;
    localparam logic [1:0] RES_PC4   = 2'b10;
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic IS_RV64 = (XLEN == 64);

    typedef struct packed {
        logic                reg_write;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic                alu_src;
        logic                srca_src;
        logic                jump_reg;
        logic                is_word_op;
        logic                is_muldiv;
        logic                illegal;
        logic [1:0]          result_src;
        logic [2:0]          imm_src;
        logic [ALUCTL_W-1:0] alu_control;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic [6:0] shift_f7_s;
    logic       legal_s;
    logic       is_div_s;
    logic       accept_s;
    logic       in_ready_s;
    logic       busy_s;
    ctrl_t      dec_s;
    ctrl_t      bundle_d;
    ctrl_t      bundle_q;
    logic       out_valid_d;
    logic       out_valid_q;
    logic       unused_instr_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    // RV64 immediate shifts carry a 6-bit shamt, so bit 25 is not part of funct.
    assign shift_f7_s = IS_RV64 ? {instr[31:26], 1'b0} : funct7_s;
    assign unused_instr_s = ^{instr[24:15], instr[11:7]};

    // Combinational instruction decode into a control bundle plus legality.
    always_comb begin
        dec_s    = ctrl_t'({CTRL_W{1'b0}});
        legal_s  = 1'b0;
        is_div_s = 1'b0;
        case (opcode_s)
            OPC_LOAD: begin
                dec_s.reg_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.result_src = RES_MEM;
                dec_s.imm_src    = IMM_I;
                dec_s.alu_control[3:0] = ALU_ADD;
                legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b001) ||
                          (funct3_s == 3'b010) || (funct3_s == 3'b100) ||
                          (funct3_s == 3'b101) ||
                          (IS_RV64 && ((funct3_s == 3'b011) || (funct3_s == 3'b110)));
            end
            OPC_STORE: begin
                dec_s.mem_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.imm_src   = IMM_S;
                dec_s.alu_control[3:0] = ALU_ADD;
                legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b001) ||
                          (funct3_s == 3'b010) || (IS_RV64 && (funct3_s == 3'b011));
            end
            OPC_OP, OPC_OP_32: begin
                dec_s.reg_write  = 1'b1;
                dec_s.is_word_op = (opcode_s == OPC_OP_32);
                if (funct7_s == 7'b0000000) begin
                    dec_s.alu_control[3:0] = {1'b0, funct3_s};
                    if (opcode_s == OPC_OP) begin
                        legal_s = 1'b1;
                    end else begin
                        legal_s = IS_RV64 && ((funct3_s == 3'b000) ||
                                  (funct3_s == 3'b001) || (funct3_s == 3'b101));
                    end
                end else if (funct7_s == 7'b0100000) begin
                    dec_s.alu_control[3:0] = {1'b1, funct3_s};
                    legal_s = ((funct3_s == 3'b000) || (funct3_s == 3'b101)) &&
                              ((opcode_s == OPC_OP) || IS_RV64);
`ifdef DECODE_MEXT_EN
                end else if (funct7_s == 7'b0000001) begin
                    dec_s.alu_control[4]   = 1'b1;
                    dec_s.alu_control[3:0] = {1'b0, funct3_s};
                    dec_s.is_muldiv        = 1'b1;
                    is_div_s               = funct3_s[2];
                    if (opcode_s == OPC_OP) begin
                        legal_s = 1'b1;
                    end else begin
                        legal_s = IS_RV64 && ((funct3_s == 3'b000) || funct3_s[2]);
                    end
`endif
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.imm_src   = IMM_I;
                case (funct3_s)
                    3'b001: begin
                        dec_s.alu_control[3:0] = 4'b0001;
                        legal_s = (shift_f7_s == 7'b0000000);
                    end
                    3'b101: begin
                        if (shift_f7_s == 7'b0000000) begin
                            dec_s.alu_control[3:0] = 4'b0101;
                            legal_s = 1'b1;
                        end else if (shift_f7_s == 7'b0100000) begin
                            dec_s.alu_control[3:0] = 4'b1101;
                            legal_s = 1'b1;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    default: begin
                        dec_s.alu_control[3:0] = {1'b0, funct3_s};
                        legal_s = 1'b1;
                    end
                endcase
            end
            OPC_OP_IMM32: begin
                dec_s.reg_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.imm_src    = IMM_I;
                dec_s.is_word_op = 1'b1;
                case (funct3_s)
                    3'b000: begin
                        dec_s.alu_control[3:0] = ALU_ADD;
                        legal_s = IS_RV64;
                    end
                    3'b001: begin
                        dec_s.alu_control[3:0] = 4'b0001;
                        legal_s = IS_RV64 && (funct7_s == 7'b0000000);
                    end
                    3'b101: begin
                        dec_s.alu_control[3:0] = {funct7_s[5], 3'b101};
                        legal_s = IS_RV64 && ((funct7_s == 7'b0000000) ||
                                              (funct7_s == 7'b0100000));
                    end
                    default: begin
                        legal_s = 1'b0;
                    end
                endcase
            end
            OPC_BRANCH: begin
                dec_s.branch  = 1'b1;
                dec_s.imm_src = IMM_B;
                dec_s.alu_control[3:0] = ALU_SUB;
                legal_s = (funct3_s != 3'b010) && (funct3_s != 3'b011);
            end
            OPC_JAL: begin
                dec_s.reg_write  = 1'b1;
                dec_s.jump       = 1'b1;
                dec_s.imm_src    = IMM_J;
                dec_s.result_src = RES_PC4;
                legal_s = 1'b1;
            end
            OPC_JALR: begin
                dec_s.reg_write  = 1'b1;
                dec_s.jump       = 1'b1;
                dec_s.jump_reg   = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.imm_src    = IMM_I;
                dec_s.result_src = RES_PC4;
                dec_s.alu_control[3:0] = ALU_ADD;
                legal_s = (funct3_s == 3'b000);
            end
            OPC_LUI: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.imm_src   = IMM_U;
                dec_s.alu_control[3:0] = ALU_PASSB;
                legal_s = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.srca_src  = 1'b1;
                dec_s.imm_src   = IMM_U;
                dec_s.alu_control[3:0] = ALU_ADD;
                legal_s = 1'b1;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        // An illegal instruction carries nothing but the illegal flag.
        if (legal_s) begin
            dec_s.illegal = 1'b0;
        end else begin
            dec_s         = ctrl_t'({CTRL_W{1'b0}});
            dec_s.illegal = 1'b1;
            is_div_s      = 1'b0;
        end
    end

    // Handshake: accept when ready, hold while stalled, drop after consume.
    always_comb begin
        in_ready_s = rst_n && !flush && !busy_s && (!out_valid_q || out_ready);
        accept_s   = in_valid && in_ready_s;
        if (accept_s) begin
            out_valid_d = 1'b1;
            bundle_d    = dec_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            bundle_d    = bundle_q;
        end else begin
            out_valid_d = out_valid_q;
            bundle_d    = bundle_q;
        end
    end

    // Output pipeline register; flush kills the bundle ahead of any accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= ctrl_t'({CTRL_W{1'b0}});
        end else if (flush) begin
            out_valid_q <= 1'b0;
            bundle_q    <= ctrl_t'({CTRL_W{1'b0}});
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

`ifdef DECODE_MEXT_EN
    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    logic [CNT_W-1:0] busy_cnt_d;
    logic [CNT_W-1:0] busy_cnt_q;

    // Divide occupancy: load on divide accept, count down, stop at zero.
    always_comb begin
        if (accept_s && is_div_s) begin
            busy_cnt_d = CNT_W'(DIV_CYCLES - 1);
        end else if (busy_cnt_q != {CNT_W{1'b0}}) begin
            busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end else begin
            busy_cnt_d = busy_cnt_q;
        end
    end

    // Occupancy counter register, cleared by reset and flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt_q <= {CNT_W{1'b0}};
        end else if (flush) begin
            busy_cnt_q <= {CNT_W{1'b0}};
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_s = (busy_cnt_q != {CNT_W{1'b0}});
`else
    localparam int unused_div_cycles = DIV_CYCLES;
    logic unused_div_s;
    assign unused_div_s = is_div_s;
    assign busy_s       = 1'b0;
`endif

    assign in_ready    = in_ready_s;
    assign busy        = busy_s;
    assign out_valid   = out_valid_q;
    assign reg_write   = bundle_q.reg_write;
    assign mem_write   = bundle_q.mem_write;
    assign jump        = bundle_q.jump;
    assign branch      = bundle_q.branch;
    assign alu_src     = bundle_q.alu_src;
    assign srca_src    = bundle_q.srca_src;
    assign jump_reg    = bundle_q.jump_reg;
    assign is_word_op  = bundle_q.is_word_op;
    assign is_muldiv   = bundle_q.is_muldiv;
    assign illegal     = bundle_q.illegal;
    assign result_src  = bundle_q.result_src;
    assign imm_src     = bundle_q.imm_src;
    assign alu_control = bundle_q.alu_control;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed, table-driven bench for decode_ctrl_stage. An RV32 and an RV64
// instance share one stimulus stream; the RV64 one checks word-op legality.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [31:0] instr;

    logic       in_ready, out_valid, busy;
    logic       reg_write, mem_write, jump, branch, alu_src, srca_src;
    logic       jump_reg, is_word_op, is_muldiv, illegal;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [4:0] alu_control;

    logic       in_ready64, out_valid64, busy64;
    logic       reg_write64, mem_write64, jump64, branch64, alu_src64, srca_src64;
    logic       jump_reg64, is_word_op64, is_muldiv64, illegal64;
    logic [1:0] result_src64;
    logic [2:0] imm_src64;
    logic [4:0] alu_control64;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.XLEN(32), .DIV_CYCLES(4), .ALUCTL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .reg_write(reg_write), .mem_write(mem_write), .jump(jump), .branch(branch),
        .alu_src(alu_src), .srca_src(srca_src), .jump_reg(jump_reg),
        .is_word_op(is_word_op), .is_muldiv(is_muldiv), .illegal(illegal),
        .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
        .busy(busy)
    );

    decode_ctrl_stage #(.XLEN(64), .DIV_CYCLES(4), .ALUCTL_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
        .reg_write(reg_write64), .mem_write(mem_write64), .jump(jump64),
        .branch(branch64), .alu_src(alu_src64), .srca_src(srca_src64),
        .jump_reg(jump_reg64), .is_word_op(is_word_op64), .is_muldiv(is_muldiv64),
        .illegal(illegal64), .result_src(result_src64), .imm_src(imm_src64),
        .alu_control(alu_control64), .busy(busy64)
    );

    logic [19:0] bundle32;
    assign bundle32 = {reg_write, mem_write, jump, branch, alu_src, srca_src,
                       jump_reg, is_word_op, is_muldiv, illegal,
                       result_src, imm_src, alu_control};

    // flags order: reg_write mem_write jump branch alu_src srca_src jump_reg
    //              is_word_op is_muldiv illegal
    // x64 = expected {reg_write, is_word_op, illegal} of the RV64 instance
    typedef struct {
        logic [31:0] instr;
        logic [9:0]  flags;
        logic [1:0]  res;
        logic [2:0]  imm;
        logic [4:0]  alu;
        logic [2:0]  x64;
        string       name;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_LW  = 32'h00012083;
    localparam logic [31:0] I_DIV = 32'h0220C1B3;
`ifdef DECODE_MEXT_EN
    localparam logic [31:0] I_HEAVY = I_DIV;
`else
    localparam logic [31:0] I_HEAVY = I_ADD;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{32'h003100B3, 10'b1000000000, 2'b00, 3'b000, 5'b00000, 3'b100, "add"};
        tbl[1]  = '{32'h403100B3, 10'b1000000000, 2'b00, 3'b000, 5'b01000, 3'b100, "sub"};
        tbl[2]  = '{32'h403150B3, 10'b1000000000, 2'b00, 3'b000, 5'b01101, 3'b100, "sra"};
        tbl[3]  = '{32'h003160B3, 10'b1000000000, 2'b00, 3'b000, 5'b00110, 3'b100, "or"};
        tbl[4]  = '{32'h403110B3, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b001, "op_bad_f7"};
        tbl[5]  = '{32'h00510093, 10'b1000100000, 2'b00, 3'b000, 5'b00000, 3'b100, "addi"};
        tbl[6]  = '{32'h40315093, 10'b1000100000, 2'b00, 3'b000, 5'b01101, 3'b100, "srai"};
        tbl[7]  = '{32'h02011093, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b100, "slli_sh32"};
        tbl[8]  = '{32'h00012083, 10'b1000100000, 2'b01, 3'b000, 5'b00000, 3'b100, "lw"};
        tbl[9]  = '{32'h00013083, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b100, "ld"};
        tbl[10] = '{32'h00312023, 10'b0100100000, 2'b00, 3'b001, 5'b00000, 3'b000, "sw"};
        tbl[11] = '{32'h00310063, 10'b0001000000, 2'b00, 3'b010, 5'b01000, 3'b000, "beq"};
        tbl[12] = '{32'h00312063, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b001, "br_bad_f3"};
        tbl[13] = '{32'h000000EF, 10'b1010000000, 2'b10, 3'b011, 5'b00000, 3'b100, "jal"};
        tbl[14] = '{32'h000100E7, 10'b1010101000, 2'b10, 3'b000, 5'b00000, 3'b100, "jalr"};
        tbl[15] = '{32'h123450B7, 10'b1000100000, 2'b00, 3'b100, 5'b01111, 3'b100, "lui"};
        tbl[16] = '{32'h00000097, 10'b1000110000, 2'b00, 3'b100, 5'b00000, 3'b100, "auipc"};
        tbl[17] = '{32'h003100BB, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b110, "addw"};
        tbl[18] = '{32'h0011009B, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b110, "addiw"};
        tbl[19] = '{32'h0000007F, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b001, "opc_7f"};
`ifdef DECODE_MEXT_EN
        tbl[20] = '{32'h023100B3, 10'b1000000010, 2'b00, 3'b000, 5'b10000, 3'b100, "mul"};
`else
        tbl[20] = '{32'h023100B3, 10'b0000000001, 2'b00, 3'b000, 5'b00000, 3'b001, "mul"};
`endif

        // Reset held two cycles
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = 32'h0;
        tick; tick;
        chk("in_ready_in_reset", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b1;
        tick;
        chk("reset_bundle", {12'h0, bundle32}, 32'h0);
        chk("reset_valid_busy_ready", {29'h0, out_valid, busy, in_ready}, 32'h1);

        // Back-to-back table vectors, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            instr    = tbl[i].instr;
            in_valid = 1'b1;
            #1;
            chk({"ready_", tbl[i].name}, {31'h0, in_ready}, 32'h1);
            tick;
            chk({"valid_", tbl[i].name}, {31'h0, out_valid}, 32'h1);
            chk({"bundle_", tbl[i].name}, {12'h0, bundle32},
                {12'h0, tbl[i].flags, tbl[i].res, tbl[i].imm, tbl[i].alu});
            chk({"rv64_", tbl[i].name}, {29'h0, reg_write64, is_word_op64, illegal64},
                {29'h0, tbl[i].x64});
        end
        in_valid = 1'b0;
        tick;
        chk("valid_drop_after_consume", {31'h0, out_valid}, 32'h0);

        // LW held under back-pressure, then consume plus accept together
        instr = I_LW; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        instr = I_ADD;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready_low", {31'h0, in_ready}, 32'h0);
            chk("stall_bundle_hold", {11'h0, out_valid, bundle32},
                {11'h0, 1'b1, tbl[8].flags, tbl[8].res, tbl[8].imm, tbl[8].alu});
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", {31'h0, in_ready}, 32'h1);
        tick;
        chk("replace_bundle", {11'h0, out_valid, bundle32},
            {11'h0, 1'b1, tbl[0].flags, tbl[0].res, tbl[0].imm, tbl[0].alu});
        in_valid = 1'b0;
        tick;

        // Divide occupancy
        instr = I_DIV; in_valid = 1'b1; out_ready = 1'b1;
        tick;
`ifdef DECODE_MEXT_EN
        chk("div_bundle", {25'h0, is_muldiv, illegal, alu_control}, {25'h0, 7'b1010100});
        instr = I_ADD;
        for (int k = 0; k < 3; k++) begin
            chk("div_busy_window", {30'h0, busy, in_ready}, 32'h2);
            tick;
        end
        chk("div_busy_end", {30'h0, busy, in_ready}, 32'h1);
        tick;
        chk("accept_after_div", {29'h0, out_valid, is_muldiv, reg_write}, 32'h5);
`else
        chk("div_illegal", {29'h0, illegal, busy, in_ready}, 32'h5);
`endif
        in_valid = 1'b0;
        tick;

        // Flush one cycle after an accept
        instr = I_HEAVY; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        chk("pre_flush_valid", {31'h0, out_valid}, 32'h1);
        flush = 1'b1; out_ready = 1'b1; instr = I_ADD;
        #1;
        chk("flush_blocks_ready", {31'h0, in_ready}, 32'h0);
        tick;
        chk("flush_kills", {30'h0, out_valid, busy}, 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("ready_after_flush", {31'h0, in_ready}, 32'h1);

        // Flush coincident with a would-be accept
        instr = I_HEAVY; in_valid = 1'b1; flush = 1'b1;
        tick;
        chk("flush_coincident", {30'h0, out_valid, busy}, 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("ready_after_coincident", {31'h0, in_ready}, 32'h1);

        // Reset in the middle of an operation
        instr = I_HEAVY; in_valid = 1'b1; out_ready = 1'b0;
        tick;
`ifdef DECODE_MEXT_EN
        chk("midop_pre", {30'h0, out_valid, busy}, 32'h3);
`else
        chk("midop_pre", {30'h0, out_valid, busy}, 32'h2);
`endif
        in_valid = 1'b0; rst_n = 1'b0;
        tick;
        chk("midop_reset", {29'h0, out_valid, busy, in_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_midop", {31'h0, in_ready}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
